// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the fetch FSM state encoding, the default bubble instruction and the
// instruction size used to advance the program counter.
package fetch_pkg;

  typedef enum logic [1:0] {
    StFetch,     // request at PC_Out, accept the response
    StDiscard,   // waiting out an abandoned request, response is dropped
    StBuffered   // response captured while decode was stalled
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall and flush.
//   clk, reset          : clock, asynchronous active-high reset
//   stall               : hold contents (ignored when flush is set)
//   flush               : load a bubble, overrides stall
//   in_valid            : in_pc/in_instr carry a real instruction; otherwise a
//                         bubble is loaded when not stalled
//   in_pc, in_instr     : candidate instruction
//   id_valid, id_pc,
//   id_instr            : register contents seen by decode
module if_id_reg #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_instr
);

  logic        valid_q;
  logic [63:0] pc_q;
  logic [31:0] instr_q;

  // A bubble keeps the previous pc; only valid and the instruction word change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else if (flush) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (!stall) begin
      if (in_valid) begin
        valid_q <= 1'b1;
        pc_q    <= in_pc;
        instr_q <= in_instr;
      end else begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end
    end
  end

  assign id_valid = valid_q;
  assign id_pc    = pc_q;
  assign id_instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory, computes the next
// PC and feeds the IF/ID register. Handles variable memory latency, decode
// stalls (one-entry skid buffer) and branch redirects (outstanding responses
// are dropped).
//   clk, reset               : clock, asynchronous active-high reset
//   PC_Out / PC_In           : current PC from / next PC to the program counter
//   imem_req, imem_addr      : instruction memory request and byte address
//   imem_ack, imem_rdata     : memory completion and instruction word
//   branch_taken,
//   branch_target            : redirect from execute
//   stall                    : decode cannot accept
//   id_valid, id_pc, id_instr: IF/ID register outputs
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] PC_Out,
  output logic [63:0] PC_In,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        stall,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_instr
);

  fetch_state_e state_q;
  logic [63:0]  discard_addr_q;
  logic         buf_valid_q;
  logic [63:0]  buf_pc_q;
  logic [31:0]  buf_instr_q;

  logic         ifid_in_valid;
  logic [63:0]  ifid_in_pc;
  logic [31:0]  ifid_in_instr;

  // Memory interface and next PC. Reset forces the request low immediately so
  // an in-flight access is abandoned without waiting for its ack.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = PC_Out;
    PC_In     = PC_Out;
    if (!reset) begin
      unique case (state_q)
        StFetch:    imem_req = 1'b1;
        StDiscard: begin
          imem_req  = 1'b1;
          imem_addr = discard_addr_q;
        end
        StBuffered: imem_req = 1'b0;
        default:    imem_req = 1'b0;
      endcase
      if (branch_taken) begin
        PC_In = branch_target;
      end else if (state_q == StFetch && imem_ack) begin
        PC_In = PC_Out + 64'(INSTR_BYTES);
      end
    end
  end

  // In FETCH+ack+stall the IF/ID register holds on its own, so the same
  // in_valid works for both the direct path and the stalled case.
  always_comb begin
    ifid_in_valid = (state_q == StFetch && imem_ack) ||
                    (state_q == StBuffered && buf_valid_q);
    ifid_in_pc    = (state_q == StBuffered) ? buf_pc_q : PC_Out;
    ifid_in_instr = (state_q == StBuffered) ? buf_instr_q : imem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StFetch;
      discard_addr_q <= '0;
      buf_valid_q    <= 1'b0;
      buf_pc_q       <= RESET_PC;
      buf_instr_q    <= NOP_INSTR;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (branch_taken) begin
            // A same-cycle ack completes the old request; otherwise wait it out.
            if (!imem_ack) begin
              discard_addr_q <= PC_Out;
              state_q        <= StDiscard;
            end
          end else if (imem_ack && stall) begin
            buf_valid_q <= 1'b1;
            buf_pc_q    <= PC_Out;
            buf_instr_q <= imem_rdata;
            state_q     <= StBuffered;
          end
        end
        StDiscard: begin
          if (!branch_taken && imem_ack) begin
            state_q <= StFetch;
          end
        end
        StBuffered: begin
          if (branch_taken || !stall) begin
            buf_valid_q <= 1'b0;
            state_q     <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  if_id_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (branch_taken),
    .in_valid (ifid_in_valid),
    .in_pc    (ifid_in_pc),
    .in_instr (ifid_in_instr),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_instr (id_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The bench plays the program counter register
// (PC_Out <= PC_In each edge) and the instruction memory (ack/rdata per row).
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [63:0] PC_Out;
  logic [63:0] PC_In;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .PC_Out        (PC_Out),
    .PC_In         (PC_In),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter register.
  always @(posedge clk or posedge reset) begin
    if (reset) PC_Out <= 64'd0;
    else       PC_Out <= PC_In;
  end

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        br;
    logic [63:0] tgt;
    logic        stl;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic [63:0] exp_pc_in;
    logic        exp_valid;
    logic [63:0] exp_id_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ack, input logic [31:0] rdata, input logic br,
                     input logic [63:0] tgt, input logic stl, input logic req,
                     input logic [63:0] addr, input logic [63:0] pc_in, input logic valid,
                     input logic [63:0] idpc, input logic [31:0] instr);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.br = br; v.tgt = tgt; v.stl = stl;
    v.exp_req = req; v.exp_addr = addr; v.exp_pc_in = pc_in;
    v.exp_valid = valid; v.exp_id_pc = idpc; v.exp_instr = instr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    //  ack rdata          br tgt      stl  req addr     pc_in    vld id_pc   instr
    // zero-latency streaming
    add(1, 32'hA000_0000, 0, 64'h0,   0,   1, 64'h0,   64'h4,   1, 64'h0,   32'hA000_0000);
    add(1, 32'hA000_0004, 0, 64'h0,   0,   1, 64'h4,   64'h8,   1, 64'h4,   32'hA000_0004);
    add(1, 32'hA000_0008, 0, 64'h0,   0,   1, 64'h8,   64'hC,   1, 64'h8,   32'hA000_0008);
    add(1, 32'hA000_000C, 0, 64'h0,   0,   1, 64'hC,   64'h10,  1, 64'hC,   32'hA000_000C);
    // two-cycle latency at 0x10
    add(0, 32'h0,         0, 64'h0,   0,   1, 64'h10,  64'h10,  0, 64'hC,   32'h13);
    add(1, 32'hA000_0010, 0, 64'h0,   0,   1, 64'h10,  64'h14,  1, 64'h10,  32'hA000_0010);
    add(1, 32'hA000_0014, 0, 64'h0,   0,   1, 64'h14,  64'h18,  1, 64'h14,  32'hA000_0014);
    add(1, 32'hA000_0018, 0, 64'h0,   0,   1, 64'h18,  64'h1C,  1, 64'h18,  32'hA000_0018);
    add(1, 32'hA000_001C, 0, 64'h0,   0,   1, 64'h1C,  64'h20,  1, 64'h1C,  32'hA000_001C);
    // ack at 0x20 under a 3-cycle stall, then release
    add(1, 32'hA000_0020, 0, 64'h0,   1,   1, 64'h20,  64'h24,  1, 64'h1C,  32'hA000_001C);
    add(0, 32'h0,         0, 64'h0,   1,   0, 64'h24,  64'h24,  1, 64'h1C,  32'hA000_001C);
    add(0, 32'h0,         0, 64'h0,   1,   0, 64'h24,  64'h24,  1, 64'h1C,  32'hA000_001C);
    add(0, 32'h0,         0, 64'h0,   0,   0, 64'h24,  64'h24,  1, 64'h20,  32'hA000_0020);
    add(0, 32'h0,         0, 64'h0,   0,   1, 64'h24,  64'h24,  0, 64'h20,  32'h13);
    // redirect with same-cycle ack: data dropped, stays in FETCH
    add(1, 32'hA000_0024, 1, 64'h40,  0,   1, 64'h24,  64'h40,  0, 64'h20,  32'h13);
    // redirect to 0x100 while 0x40 is outstanding
    add(0, 32'h0,         0, 64'h0,   0,   1, 64'h40,  64'h40,  0, 64'h20,  32'h13);
    add(0, 32'h0,         1, 64'h100, 0,   1, 64'h40,  64'h100, 0, 64'h20,  32'h13);
    add(0, 32'h0,         0, 64'h0,   0,   1, 64'h40,  64'h100, 0, 64'h20,  32'h13);
    add(1, 32'hDEAD_BEEF, 0, 64'h0,   0,   1, 64'h40,  64'h100, 0, 64'h20,  32'h13);
    add(1, 32'hA000_0100, 0, 64'h0,   0,   1, 64'h100, 64'h104, 1, 64'h100, 32'hA000_0100);
    // redirect to 0x200 while BUFFERED with stall held
    add(1, 32'hA000_0104, 0, 64'h0,   1,   1, 64'h104, 64'h108, 1, 64'h100, 32'hA000_0100);
    add(0, 32'h0,         1, 64'h200, 1,   0, 64'h108, 64'h200, 0, 64'h100, 32'h13);
    add(1, 32'hA000_0200, 0, 64'h0,   0,   1, 64'h200, 64'h204, 1, 64'h200, 32'hA000_0200);
    // enter DISCARD, redirect again inside DISCARD
    add(0, 32'h0,         1, 64'h300, 0,   1, 64'h204, 64'h300, 0, 64'h200, 32'h13);
    add(0, 32'h0,         1, 64'h400, 0,   1, 64'h204, 64'h400, 0, 64'h200, 32'h13);
    add(0, 32'h0,         0, 64'h0,   0,   1, 64'h204, 64'h400, 0, 64'h200, 32'h13);

    // Reset state, with busy-looking inputs that must be ignored.
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    branch_taken = 1'b1; branch_target = 64'h999; stall = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("reset id_valid", 64'(id_valid), 64'd0);
    check("reset id_pc",    id_pc,         64'd0);
    check("reset id_instr", 64'(id_instr), 64'h13);
    check("reset imem_req", 64'(imem_req), 64'd0);
    check("reset PC_In",    PC_In,         64'd0);
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      branch_taken = vecs[i].br; branch_target = vecs[i].tgt; stall = vecs[i].stl;
      #2;
      check($sformatf("row%0d imem_req", i),  64'(imem_req), 64'(vecs[i].exp_req));
      check($sformatf("row%0d imem_addr", i), imem_addr,     vecs[i].exp_addr);
      check($sformatf("row%0d PC_In", i),     PC_In,         vecs[i].exp_pc_in);
      @(posedge clk);
      #1;
      check($sformatf("row%0d id_valid", i), 64'(id_valid), 64'(vecs[i].exp_valid));
      check($sformatf("row%0d id_pc", i),    id_pc,         vecs[i].exp_id_pc);
      check($sformatf("row%0d id_instr", i), 64'(id_instr), 64'(vecs[i].exp_instr));
    end

    // Still in DISCARD for 0x204; assert reset mid-cycle, no ack ever arrives.
    @(negedge clk);
    imem_ack = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midreset imem_req", 64'(imem_req), 64'd0);
    check("midreset id_valid", 64'(id_valid), 64'd0);
    check("midreset id_pc",    id_pc,         64'd0);
    check("midreset id_instr", 64'(id_instr), 64'h13);
    check("midreset PC_In",    PC_In,         64'd0);
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hB000_0000;
    #2;
    check("restart imem_req",  64'(imem_req), 64'd1);
    check("restart imem_addr", imem_addr,     64'd0);
    check("restart PC_In",     PC_In,         64'd4);
    @(posedge clk);
    #1;
    check("restart id_valid", 64'(id_valid), 64'd1);
    check("restart id_pc",    id_pc,         64'd0);
    check("restart id_instr", 64'(id_instr), 64'hB000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'd0, SHALL be the id_pc value loaded at reset and SHALL match the program counter's reset value.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, SHALL be the id_instr value for a bubble.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 PC_Out  input  64  current PC from the program counter.
REQ-006 PC_In  output  64  next PC to the program counter; combinational.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  64  instruction memory byte address.
REQ-009 imem_ack  input  1  memory completion; may assert in the same cycle as imem_req.
REQ-010 imem_rdata  input  32  instruction word; valid only while imem_ack=1.
REQ-011 branch_taken  input  1  redirect request from execute.
REQ-012 branch_target  input  64  redirect address; used only while branch_taken=1.
REQ-013 stall  input  1  decode cannot accept; IF/ID SHALL hold.
REQ-014 id_valid  output  1  IF/ID holds a real instruction.
REQ-015 id_pc  output  64  PC of the IF/ID instruction.
REQ-016 id_instr  output  32  IF/ID instruction word.

Function
REQ-017 The FSM SHALL have exactly three states: FETCH, DISCARD and BUFFERED.
REQ-018 FETCH: imem_req=1, imem_addr=PC_Out.
REQ-019 DISCARD: imem_req=1, imem_addr=the latched address of the abandoned request, held stable until imem_ack.
REQ-020 BUFFERED: imem_req=0.
REQ-021 PC_In SHALL be selected by priority: branch_taken=1 gives branch_target; else an accepted ack in FETCH gives PC_Out+4 (modulo 2^64); else PC_Out.
REQ-022 An ack in FETCH with branch_taken=0 and stall=0 SHALL load IF/ID with {PC_Out, imem_rdata}, set id_valid=1, and remain in FETCH.
REQ-023 An ack in FETCH with branch_taken=0 and stall=1 SHALL capture {PC_Out, imem_rdata} in a one-entry buffer and go to BUFFERED; IF/ID SHALL be unchanged.
REQ-024 In BUFFERED with stall=0, IF/ID SHALL load the buffer contents, id_valid SHALL be 1, and the FSM SHALL go to FETCH.
REQ-025 FETCH with no ack and stall=0 SHALL load a bubble into IF/ID: id_valid=0, id_instr=NOP_INSTR.
REQ-026 In FETCH, branch_taken=1 without imem_ack SHALL latch imem_addr and go to DISCARD.
REQ-027 In FETCH, branch_taken=1 with imem_ack SHALL drop the returned data and remain in FETCH.
REQ-028 In DISCARD, imem_ack SHALL drop the returned data and go to FETCH.
REQ-029 branch_taken=1 SHALL flush IF/ID (id_valid=0, id_instr=NOP_INSTR) on the next edge and SHALL override stall.
REQ-030 In BUFFERED, branch_taken=1 SHALL additionally invalidate the buffer and go to FETCH.
REQ-031 branch_taken=1 while in DISCARD SHALL update PC_In and SHALL keep the FSM in DISCARD.
REQ-032 With a zero-latency memory and stall=0, throughput SHALL be one instruction per cycle; fetch-to-id latency SHALL be one cycle.
REQ-033 A discarded response SHALL never reach IF/ID.

Reset
REQ-034 While reset=1: state=FETCH, id_valid=0, id_pc=RESET_PC, id_instr=NOP_INSTR, buffer invalid, imem_req=0, PC_In=PC_Out.
REQ-035 Reset asserted mid-request SHALL abandon the request without waiting for imem_ack.

Structure
REQ-036 A shared fetch_pkg SHALL hold the state enumeration, the NOP_INSTR default and the constant INSTR_BYTES=4.
REQ-037 The IF/ID register with stall and flush SHALL be a sub-module named if_id_reg.

Verification
REQ-038 Zero-latency memory, stall=0: id_pc SHALL be 0,4,8,12 on consecutive cycles, with PC_In one step ahead.
REQ-039 Two-cycle memory latency: imem_req and imem_addr=0x10 SHALL be stable for 2 cycles, PC_In SHALL stay 0x10 until ack, then become 0x14, and one bubble SHALL precede id_pc=0x10.
REQ-040 Ack at PC 0x20 with stall=1 for 3 cycles: the FSM SHALL be in BUFFERED, imem_req=0 and PC_In=0x24 held; after stall drops, id_pc=0x20 SHALL appear once.
REQ-041 Redirect to 0x100 during an outstanding request for 0x40: the late response SHALL be dropped, the next request address SHALL be 0x100, and the next valid id_pc SHALL be 0x100.
REQ-042 Redirect to 0x200 while BUFFERED with stall=1: id_valid=0 SHALL follow on the next edge, the buffer SHALL be lost, and the first valid id_pc SHALL be 0x200.
REQ-043 Reset asserted mid-DISCARD: outputs SHALL reach reset values immediately, and fetch SHALL restart at 0 after release.
